// File: rtl/frac_clk_div.sv
// Fractional clock divider: average period cfg_int + cfg_num/cfg_den sys_clk cycles,
// Bresenham-spread long periods, boundary-shadowed config. Define FRAC_CLK_DIV_STAT_EN for long_cnt.
module frac_clk_div #(
  parameter int CNT_W   = 8,
  parameter int FRAC_W  = 8,
  parameter int DEF_INT = 8,
  parameter int DEF_NUM = 7,
  parameter int DEF_DEN = 10
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              en,
  input  logic [CNT_W-1:0]  cfg_int,
  input  logic [FRAC_W-1:0] cfg_num,
  input  logic [FRAC_W-1:0] cfg_den,
  input  logic              cfg_load,
  output logic              cfg_pend,
  output logic              cfg_err,
  output logic              clk_out,
  output logic              clk_pulse
`ifdef FRAC_CLK_DIV_STAT_EN
  ,
  output logic [15:0]       long_cnt
`endif
);

  localparam logic [CNT_W-1:0]  INT_MIN  = CNT_W'(2);
  localparam logic [CNT_W-1:0]  INT_MAX  = CNT_W'((1 << CNT_W) - 2);
  localparam logic [CNT_W-1:0]  RST_INT  = CNT_W'(DEF_INT);
  localparam logic [FRAC_W-1:0] RST_NUM  = FRAC_W'(DEF_NUM);
  localparam logic [FRAC_W-1:0] RST_DEN  = FRAC_W'(DEF_DEN);
  localparam logic [CNT_W-1:0]  CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [FRAC_W-1:0] FRAC_ZERO = {FRAC_W{1'b0}};

  logic [CNT_W-1:0]  r_act_int,  r_pend_int,  r_cnt, r_len;
  logic [FRAC_W-1:0] r_act_num,  r_pend_num,  r_acc;
  logic [FRAC_W-1:0] r_act_den,  r_pend_den;
  logic              r_pend, r_cfg_err, r_clk_out, r_clk_pulse;

  logic              w_cfg_legal, w_boundary, w_apply, w_sum_ge;
  logic [FRAC_W:0]   w_sum;
  logic [CNT_W:0]    w_half;
  logic [CNT_W-1:0]  w_act_int_nxt, w_pend_int_nxt, w_cnt_nxt, w_len_nxt;
  logic [FRAC_W-1:0] w_act_num_nxt, w_pend_num_nxt, w_acc_nxt;
  logic [FRAC_W-1:0] w_act_den_nxt, w_pend_den_nxt;
  logic              w_pend_nxt, w_cfg_err_nxt, w_clk_out_nxt, w_clk_pulse_nxt;

  // Decode: config validation, period boundary and Bresenham step.
  always_comb begin
    w_cfg_legal = (cfg_int >= INT_MIN) && (cfg_int <= INT_MAX) &&
                  (cfg_den != FRAC_ZERO) && (cfg_num < cfg_den);
    w_boundary  = (r_cnt == (r_len - CNT_ONE));
    w_apply     = r_pend && (!en || w_boundary);
    w_sum       = {1'b0, r_acc} + {1'b0, r_act_num};
    w_sum_ge    = (w_sum >= {1'b0, r_act_den});
    w_half      = ({1'b0, r_len} + {{CNT_W{1'b0}}, 1'b1}) >> 1;
  end

  // Next state for counter, accumulator, period length and configuration.
  always_comb begin
    w_cnt_nxt      = r_cnt;
    w_acc_nxt      = r_acc;
    w_len_nxt      = r_len;
    w_act_int_nxt  = r_act_int;
    w_act_num_nxt  = r_act_num;
    w_act_den_nxt  = r_act_den;
    w_pend_int_nxt = r_pend_int;
    w_pend_num_nxt = r_pend_num;
    w_pend_den_nxt = r_pend_den;
    w_pend_nxt     = r_pend;

    if (!en) begin
      w_cnt_nxt = CNT_ZERO;
      w_acc_nxt = FRAC_ZERO;
      w_len_nxt = r_act_int;
    end else if (w_boundary) begin
      w_cnt_nxt = CNT_ZERO;
      if (r_pend) begin
        w_acc_nxt = FRAC_ZERO;
      end else if (w_sum_ge) begin
        w_acc_nxt = FRAC_W'(w_sum - {1'b0, r_act_den});
        w_len_nxt = r_act_int + CNT_ONE;
      end else begin
        w_acc_nxt = w_sum[FRAC_W-1:0];
        w_len_nxt = r_act_int;
      end
    end else begin
      w_cnt_nxt = r_cnt + CNT_ONE;
    end

    // An apply always restarts with the plain integer length of the new config.
    if (w_apply) begin
      w_len_nxt     = r_pend_int;
      w_act_int_nxt = r_pend_int;
      w_act_num_nxt = r_pend_num;
      w_act_den_nxt = r_pend_den;
    end else begin
      w_act_int_nxt = r_act_int;
    end

    // A load landing with an apply is kept pending for the following boundary.
    if (cfg_load && w_cfg_legal) begin
      w_pend_nxt     = 1'b1;
      w_pend_int_nxt = cfg_int;
      w_pend_num_nxt = cfg_num;
      w_pend_den_nxt = cfg_den;
    end else if (w_apply) begin
      w_pend_nxt = 1'b0;
    end else begin
      w_pend_nxt = r_pend;
    end
  end

  // Next state for the registered outputs.
  always_comb begin
    w_cfg_err_nxt   = cfg_load && !w_cfg_legal;
    w_clk_out_nxt   = en && ({1'b0, r_cnt} < w_half);
    w_clk_pulse_nxt = en && (r_cnt == CNT_ZERO);
  end

  // State and output registers.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_cnt       <= CNT_ZERO;
      r_acc       <= FRAC_ZERO;
      r_len       <= RST_INT;
      r_act_int   <= RST_INT;
      r_act_num   <= RST_NUM;
      r_act_den   <= RST_DEN;
      r_pend_int  <= RST_INT;
      r_pend_num  <= RST_NUM;
      r_pend_den  <= RST_DEN;
      r_pend      <= 1'b0;
      r_cfg_err   <= 1'b0;
      r_clk_out   <= 1'b0;
      r_clk_pulse <= 1'b0;
    end else begin
      r_cnt       <= w_cnt_nxt;
      r_acc       <= w_acc_nxt;
      r_len       <= w_len_nxt;
      r_act_int   <= w_act_int_nxt;
      r_act_num   <= w_act_num_nxt;
      r_act_den   <= w_act_den_nxt;
      r_pend_int  <= w_pend_int_nxt;
      r_pend_num  <= w_pend_num_nxt;
      r_pend_den  <= w_pend_den_nxt;
      r_pend      <= w_pend_nxt;
      r_cfg_err   <= w_cfg_err_nxt;
      r_clk_out   <= w_clk_out_nxt;
      r_clk_pulse <= w_clk_pulse_nxt;
    end
  end

  assign cfg_pend  = r_pend;
  assign cfg_err   = r_cfg_err;
  assign clk_out   = r_clk_out;
  assign clk_pulse = r_clk_pulse;

`ifdef FRAC_CLK_DIV_STAT_EN
  logic [15:0] r_long_cnt;
  logic [15:0] w_long_cnt_nxt;
  logic        w_long_end;

  // Long-period statistic: a boundary closing an int+1 period bumps the count.
  always_comb begin
    w_long_end = w_boundary && (r_len == (r_act_int + CNT_ONE));
    if (!en || w_apply) begin
      w_long_cnt_nxt = 16'h0000;
    end else if (w_long_end && (r_long_cnt != 16'hFFFF)) begin
      w_long_cnt_nxt = r_long_cnt + 16'h0001;
    end else begin
      w_long_cnt_nxt = r_long_cnt;
    end
  end

  // Long-period counter register.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_long_cnt <= 16'h0000;
    end else begin
      r_long_cnt <= w_long_cnt_nxt;
    end
  end

  assign long_cnt = r_long_cnt;
`endif

endmodule

// File: tb/tb_frac_clk_div.sv
// Directed bench for frac_clk_div: period sequences, config shadowing, rejects, disable, reset.
module tb_frac_clk_div;

  logic       sys_clk;
  logic       sys_rst_n;
  logic       en;
  logic [7:0] cfg_int;
  logic [7:0] cfg_num;
  logic [7:0] cfg_den;
  logic       cfg_load;
  logic       cfg_pend;
  logic       cfg_err;
  logic       clk_out;
  logic       clk_pulse;

  int n_checks = 0;
  int n_errors = 0;

  frac_clk_div dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .en        (en),
    .cfg_int   (cfg_int),
    .cfg_num   (cfg_num),
    .cfg_den   (cfg_den),
    .cfg_load  (cfg_load),
    .cfg_pend  (cfg_pend),
    .cfg_err   (cfg_err),
    .clk_out   (clk_out),
    .clk_pulse (clk_pulse)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // Called on a negedge where clk_pulse is high; returns on the next such negedge.
  task automatic measure_period(output int len, output int hi);
    int guard;
    bit done;
    len = 1;
    hi = (clk_out === 1'b1) ? 1 : 0;
    guard = 0;
    done = 1'b0;
    while (!done && guard < 600) begin
      @(negedge sys_clk);
      guard++;
      if (clk_pulse === 1'b1) done = 1'b1;
      else begin
        len++;
        if (clk_out === 1'b1) hi++;
      end
    end
  endtask

  task automatic wait_pulse();
    int guard;
    bit seen;
    guard = 0;
    seen = 1'b0;
    while (!seen && guard < 600) begin
      @(negedge sys_clk);
      guard++;
      if (clk_pulse === 1'b1) seen = 1'b1;
    end
    n_checks++;
    if (!seen) begin
      n_errors++;
      $display("FAIL wait_pulse: got no clk_pulse within %0d cycles, required one", guard);
    end
  endtask

  task automatic drive_load(input logic [7:0] i, input logic [7:0] n, input logic [7:0] d);
    cfg_int = i;
    cfg_num = n;
    cfg_den = d;
    cfg_load = 1'b1;
  endtask

  task automatic test_reset();
    sys_rst_n = 1'b0;
    en = 1'b1;
    cfg_load = 1'b0;
    cfg_int = 8'd0;
    cfg_num = 8'd0;
    cfg_den = 8'd0;
    #2;
    n_checks++;
    if ({cfg_pend, cfg_err, clk_out, clk_pulse} !== 4'b0000) begin
      n_errors++;
      $display("FAIL reset_outputs: got %b, required 0000", {cfg_pend, cfg_err, clk_out, clk_pulse});
    end
    repeat (3) @(negedge sys_clk);
    n_checks++;
    if ({cfg_pend, cfg_err, clk_out, clk_pulse} !== 4'b0000) begin
      n_errors++;
      $display("FAIL reset_held: got %b, required 0000", {cfg_pend, cfg_err, clk_out, clk_pulse});
    end
    sys_rst_n = 1'b1;
    wait_pulse();
  endtask

  task automatic test_default_seq();
    int exp_len[11] = '{8, 8, 9, 9, 8, 9, 9, 8, 9, 9, 9};
    int l, h, tot;
    tot = 0;
    for (int i = 0; i < 11; i++) begin
      measure_period(l, h);
      n_checks++;
      if (l !== exp_len[i]) begin
        n_errors++;
        $display("FAIL default_len[%0d]: got %0d, required %0d", i, l, exp_len[i]);
      end
      n_checks++;
      if (h !== (exp_len[i] + 1) / 2) begin
        n_errors++;
        $display("FAIL default_high[%0d]: got %0d, required %0d", i, h, (exp_len[i] + 1) / 2);
      end
      if (i > 0) tot += l;
    end
    n_checks++;
    if (tot !== 87) begin
      n_errors++;
      $display("FAIL default_total: got %0d, required 87", tot);
    end
  endtask

  // Starts on the first cycle of an 8-cycle period.
  task automatic test_int2();
    int n, guard, l, h;
    bit done;
    n = 1;
    repeat (3) begin
      @(negedge sys_clk);
      n++;
    end
    drive_load(8'd2, 8'd0, 8'd1);
    @(negedge sys_clk);
    n++;
    cfg_load = 1'b0;
    n_checks++;
    if (cfg_pend !== 1'b1) begin
      n_errors++;
      $display("FAIL int2_pend_set: got %b, required 1", cfg_pend);
    end
    done = 1'b0;
    guard = 0;
    while (!done && guard < 100) begin
      @(negedge sys_clk);
      guard++;
      if (clk_pulse === 1'b1) done = 1'b1;
      else n++;
    end
    n_checks++;
    if (n !== 8) begin
      n_errors++;
      $display("FAIL int2_old_period: got %0d, required 8", n);
    end
    n_checks++;
    if (cfg_pend !== 1'b0) begin
      n_errors++;
      $display("FAIL int2_pend_clear: got %b, required 0", cfg_pend);
    end
    for (int i = 0; i < 4; i++) begin
      measure_period(l, h);
      n_checks++;
      if (l !== 2 || h !== 1) begin
        n_errors++;
        $display("FAIL int2_period[%0d]: got len %0d high %0d, required len 2 high 1", i, l, h);
      end
    end
  endtask

  // Starts on the first cycle of a 2-cycle period.
  task automatic test_frac_3_1_2();
    int exp_len[6] = '{2, 3, 3, 4, 3, 4};
    int l, h;
    @(negedge sys_clk);
    drive_load(8'd3, 8'd1, 8'd2);
    @(negedge sys_clk);
    cfg_load = 1'b0;
    n_checks++;
    if (cfg_pend !== 1'b1) begin
      n_errors++;
      $display("FAIL frac_pend_set: got %b, required 1", cfg_pend);
    end
    for (int i = 0; i < 6; i++) begin
      measure_period(l, h);
      n_checks++;
      if (l !== exp_len[i] || h !== (exp_len[i] + 1) / 2) begin
        n_errors++;
        $display("FAIL frac_period[%0d]: got len %0d high %0d, required len %0d high %0d",
                 i, l, h, exp_len[i], (exp_len[i] + 1) / 2);
      end
    end
  endtask

  // Starts on the first cycle of a 3-cycle period of the 3,4 alternation.
  task automatic test_illegal();
    logic [7:0] bad_int[3] = '{8'd1, 8'd3, 8'd3};
    logic [7:0] bad_num[3] = '{8'd0, 8'd0, 8'd5};
    logic [7:0] bad_den[3] = '{8'd1, 8'd0, 8'd5};
    int l, h;
    for (int i = 0; i < 3; i++) begin
      drive_load(bad_int[i], bad_num[i], bad_den[i]);
      @(negedge sys_clk);
      cfg_load = 1'b0;
      n_checks++;
      if (cfg_err !== 1'b1 || cfg_pend !== 1'b0) begin
        n_errors++;
        $display("FAIL illegal_reject[%0d]: got err %b pend %b, required err 1 pend 0", i, cfg_err, cfg_pend);
      end
      @(negedge sys_clk);
      n_checks++;
      if (cfg_err !== 1'b0 || cfg_pend !== 1'b0) begin
        n_errors++;
        $display("FAIL illegal_pulse[%0d]: got err %b pend %b, required err 0 pend 0", i, cfg_err, cfg_pend);
      end
    end
    wait_pulse();
    measure_period(l, h);
    n_checks++;
    if (l !== 3) begin
      n_errors++;
      $display("FAIL illegal_seq_a: got %0d, required 3", l);
    end
    measure_period(l, h);
    n_checks++;
    if (l !== 4) begin
      n_errors++;
      $display("FAIL illegal_seq_b: got %0d, required 4", l);
    end
  endtask

  // Starts on the first cycle of a 3-cycle period; second load lands on its boundary.
  task automatic test_back_to_back();
    int l, h;
    drive_load(8'd5, 8'd0, 8'd1);
    @(negedge sys_clk);
    drive_load(8'd4, 8'd0, 8'd1);
    @(negedge sys_clk);
    cfg_load = 1'b0;
    n_checks++;
    if (cfg_pend !== 1'b1 || cfg_err !== 1'b0) begin
      n_errors++;
      $display("FAIL b2b_pend_after_boundary: got pend %b err %b, required pend 1 err 0", cfg_pend, cfg_err);
    end
    wait_pulse();
    n_checks++;
    if (cfg_pend !== 1'b1) begin
      n_errors++;
      $display("FAIL b2b_newer_waits: got %b, required 1", cfg_pend);
    end
    measure_period(l, h);
    n_checks++;
    if (l !== 5 || h !== 3) begin
      n_errors++;
      $display("FAIL b2b_older_applied: got len %0d high %0d, required len 5 high 3", l, h);
    end
    n_checks++;
    if (cfg_pend !== 1'b0) begin
      n_errors++;
      $display("FAIL b2b_newer_applied_pend: got %b, required 0", cfg_pend);
    end
    for (int i = 0; i < 2; i++) begin
      measure_period(l, h);
      n_checks++;
      if (l !== 4 || h !== 2) begin
        n_errors++;
        $display("FAIL b2b_newer_period[%0d]: got len %0d high %0d, required len 4 high 2", i, l, h);
      end
    end
  endtask

  // Starts on the first cycle of a 4-cycle period.
  task automatic test_disable();
    int exp_len[3] = '{6, 6, 7};
    int l, h;
    @(negedge sys_clk);
    drive_load(8'd6, 8'd1, 8'd2);
    @(negedge sys_clk);
    cfg_load = 1'b0;
    en = 1'b0;
    n_checks++;
    if (cfg_pend !== 1'b1) begin
      n_errors++;
      $display("FAIL dis_pend_before: got %b, required 1", cfg_pend);
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge sys_clk);
      n_checks++;
      if ({clk_out, clk_pulse, cfg_pend} !== 3'b000) begin
        n_errors++;
        $display("FAIL dis_low[%0d]: got out/pulse/pend %b, required 000", k, {clk_out, clk_pulse, cfg_pend});
      end
    end
    en = 1'b1;
    @(negedge sys_clk);
    n_checks++;
    if (clk_pulse !== 1'b1 || clk_out !== 1'b1) begin
      n_errors++;
      $display("FAIL dis_restart: got pulse %b out %b, required 1 1", clk_pulse, clk_out);
    end
    for (int i = 0; i < 3; i++) begin
      measure_period(l, h);
      n_checks++;
      if (l !== exp_len[i] || h !== (exp_len[i] + 1) / 2) begin
        n_errors++;
        $display("FAIL dis_new_cfg[%0d]: got len %0d high %0d, required len %0d high %0d",
                 i, l, h, exp_len[i], (exp_len[i] + 1) / 2);
      end
    end
  endtask

  // Starts on the first cycle of a 6-cycle period.
  task automatic test_reset_mid();
    int exp_len[3] = '{8, 8, 9};
    int l, h;
    drive_load(8'd3, 8'd0, 8'd1);
    @(negedge sys_clk);
    cfg_load = 1'b0;
    n_checks++;
    if (cfg_pend !== 1'b1 || clk_out !== 1'b1) begin
      n_errors++;
      $display("FAIL rstmid_pre: got pend %b out %b, required 1 1", cfg_pend, clk_out);
    end
    #2;
    sys_rst_n = 1'b0;
    #1;
    n_checks++;
    if ({cfg_pend, cfg_err, clk_out, clk_pulse} !== 4'b0000) begin
      n_errors++;
      $display("FAIL rstmid_async: got %b, required 0000", {cfg_pend, cfg_err, clk_out, clk_pulse});
    end
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    wait_pulse();
    for (int i = 0; i < 3; i++) begin
      measure_period(l, h);
      n_checks++;
      if (l !== exp_len[i] || h !== (exp_len[i] + 1) / 2) begin
        n_errors++;
        $display("FAIL rstmid_default[%0d]: got len %0d high %0d, required len %0d high %0d",
                 i, l, h, exp_len[i], (exp_len[i] + 1) / 2);
      end
    end
  endtask

  initial begin
    test_reset();
    test_default_seq();
    test_int2();
    test_frac_3_1_2();
    test_illegal();
    test_back_to_back();
    test_disable();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
